data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and array access (range 0..15).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-005 The module SHALL have port req_valid  input  1  meaning the MEM-stage request is present.
REQ-006 The module SHALL have port req_ready  output  1  meaning the responder accepts a request this cycle.
REQ-007 The module SHALL have port req_we  input  1  meaning 1=store, 0=load.
REQ-008 The module SHALL have port req_addr  input  32  meaning the byte address.
REQ-009 The module SHALL have port req_wdata  input  32  meaning the store data.
REQ-010 The module SHALL have port req_be  input  4  meaning the store byte enables, where bit i covers byte lane i.
REQ-011 The module SHALL have port rsp_valid  output  1  meaning a response is present.
REQ-012 The module SHALL have port rsp_ready  input  1  meaning the core accepts the response.
REQ-013 The module SHALL have port rsp_rdata  output  32  meaning the load data, which is 0 for stores.
REQ-014 The module SHALL have port rsp_err  output  1  meaning the access faulted.

Function
REQ-015 The module SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 The module SHALL drive req_ready=1 only in IDLE.
REQ-017 The module SHALL treat a request as accepted on a cycle where req_valid and req_ready are both 1, and SHALL latch req_we, req_addr, req_wdata and req_be on that edge.
REQ-018 On acceptance the module SHALL go IDLE->WAIT with the wait counter loaded to LATENCY.
REQ-019 If LATENCY=0 the module SHALL go IDLE->RESP directly.
REQ-020 In WAIT the module SHALL decrement the counter each cycle, and on the edge where the counter is 0 it SHALL perform the array access and go to RESP.
REQ-021 The module SHALL assert rsp_valid exactly LATENCY+1 cycles after the acceptance edge.
REQ-022 For a store the module SHALL write only the byte lanes with req_be[i]=1 into word index req_addr[log2(DEPTH_WORDS)+1:2], leaving the other lanes unchanged.
REQ-023 For a store with req_be=0 the module SHALL change no memory and SHALL still respond.
REQ-024 For a load the module SHALL capture the full word into rsp_rdata, with req_be ignored.
REQ-025 The module SHALL remain in RESP with rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready=1, then go RESP->IDLE on that edge.
REQ-026 The module SHALL NOT accept a new request in the same cycle as the response handshake (req_ready=0 in RESP), giving a minimum issue interval of LATENCY+2 cycles.
REQ-027 A load issued after a store has responded SHALL observe the stored data.
REQ-028 While req_ready=0, the request inputs SHALL be ignored.

Reset
REQ-029 When rst=1 at a clock edge, the module SHALL enter IDLE and set rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter to 0, with req_ready=1 in the cycle after reset deasserts.
REQ-030 If reset is asserted in WAIT, the module SHALL abort the pending access, and an uncommitted store SHALL NOT modify memory.
REQ-031 If reset is asserted in RESP, the module SHALL drop the response.
REQ-032 Reset SHALL NOT clear the storage array, whose contents persist across reset.

Configuration
REQ-033 With macro DMEM_BOUNDS_CHECK_EN defined, the module SHALL flag an access with rsp_err=1 when req_addr[1:0]!=0 or req_addr>=4*DEPTH_WORDS; such stores SHALL write nothing, and such loads SHALL return rsp_rdata=0.
REQ-034 With DMEM_BOUNDS_CHECK_EN defined, a faulted access SHALL keep identical latency and handshake to a normal access.
REQ-035 Without DMEM_BOUNDS_CHECK_EN, the module SHALL ignore req_addr[1:0], wrap the address modulo 4*DEPTH_WORDS, and tie rsp_err to 0.

Verification
REQ-036 Scenario 1 (LATENCY=2): store addr 0x10, wdata 0xDEADBEEF, be 0xF accepted at cycle 5 -> rsp_valid=1 at cycle 8, rsp_rdata=0; a subsequent load of 0x10 returns 0xDEADBEEF.
REQ-037 Scenario 2: word 0x10 holds 0xDEADBEEF; store wdata 0x11223344, be 0x5 -> a subsequent load returns 0xDE22BE44.
REQ-038 Scenario 3: a load is pending and rsp_ready is held 0 for 4 cycles -> rsp_valid and rsp_rdata are stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-039 Scenario 4: rst pulsed during WAIT of a store of 0xCAFEF00D to 0x20 that previously held 0 -> no response, and a load of 0x20 after reset returns 0.
REQ-040 Scenario 5 (DMEM_BOUNDS_CHECK_EN, DEPTH_WORDS=1024): load 0x1002 -> rsp_err=1, rsp_rdata=0; store to 0x1000 -> rsp_err=1 and word 0 is unchanged. Without the macro, a store to 0x1000 writes word 0.
REQ-041 Scenario 6 (LATENCY=0): back-to-back requests with rsp_ready tied 1 -> rsp_valid occurs 1 cycle after each acceptance, with acceptances every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with a fixed access latency.
// A request is accepted only in IDLE, waits LATENCY cycles, touches the
// word array once, then holds the response until the core takes it.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to fault misaligned or
// out-of-range accesses (rsp_err=1, no write, load data 0).
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. The responder never accepts a request
// in the same cycle as a response transfer, and ignores request inputs
// whenever req_ready is 0.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        do_access;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_idx;
    logic        acc_fault;
    logic [31:0] rd_word;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

    // Select the request that touches the array: live inputs for a
    // zero-latency access straight out of IDLE, latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx = acc_addr[AW+1:2];
        rd_word = mem[acc_idx];
        do_access = 1'b0;
        if (state_q == ST_IDLE && accept && LATENCY == 0) begin
            do_access = 1'b1;
        end
        // The counter reaches 0 on this edge: the access happens now.
        if (state_q == ST_WAIT && cnt_q <= 4'd1) begin
            do_access = 1'b1;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    // Fault on misalignment or on a byte address beyond the array.
    always_comb begin
        acc_fault = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
    end
`else
    // Low address bits are ignored and upper bits wrap; never faults.
    logic unused_addr_bits;
    always_comb begin
        acc_fault        = 1'b0;
        unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
    end
`endif

    // Next-state and response computation for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (do_access) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (do_access) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_fault;
            rsp_rdata_d = (!acc_we && !acc_fault) ? rd_word : 32'd0;
        end
    end

    // Control and response registers; reset drops any pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store into the array; contents survive reset, and a store
    // whose access edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance for most scenarios and
// a LATENCY=0 instance with rsp_ready tied high for back-to-back traffic.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    logic        req_valid_0, req_we_0;
    logic [31:0] req_addr_0, req_wdata_0;
    logic [3:0]  req_be_0;
    logic        req_ready_0, rsp_valid_0, rsp_err_0;
    logic [31:0] rsp_rdata_0;
    logic [1:0]  dbg_state_0;

    int tests;
    int failed;
    int cyc;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_0), .req_ready(req_ready_0), .req_we(req_we_0),
        .req_addr(req_addr_0), .req_wdata(req_wdata_0), .req_be(req_be_0),
        .rsp_valid(rsp_valid_0), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata_0),
        .rsp_err(rsp_err_0), .dbg_state(dbg_state_0)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One full transaction on the LATENCY=2 instance; lat is the number of
    // cycles from the acceptance edge to rsp_valid, -1 on timeout.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL issue_ready: got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata;
        er = rsp_err;
        if (!rsp_valid) lat = -1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_err, rsp_rdata, dbg_state} !== 36'd0) begin
            failed++;
            $display("FAIL reset_outputs: got v=%b e=%b d=%h s=%0d exp all 0",
                     rsp_valid, rsp_err, rsp_rdata, dbg_state);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_ready: got %b exp 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        tests++;
        if ({lat, rd, er} !== {32'd3, 32'd0, 1'b0}) begin
            failed++;
            $display("FAIL store_rsp: got lat=%0d d=%h e=%b exp lat=3 d=0 e=0", lat, rd, er);
        end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if ({lat, rd, er} !== {32'd3, 32'hDEADBEEF, 1'b0}) begin
            failed++;
            $display("FAIL load_after_store: got lat=%0d d=%h e=%b exp lat=3 d=deadbeef e=0", lat, rd, er);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, 32'h11223344, 4'h5, rd, er, lat);
        issue(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        tests++;
        if (rd !== 32'hDE22BE44) begin
            failed++;
            $display("FAIL partial_store: got %h exp de22be44", rd);
        end
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        tests++;
        if (lat !== 3) begin
            failed++;
            $display("FAIL be0_responds: got lat=%0d exp 3", lat);
        end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if (rd !== 32'hDE22BE44) begin
            failed++;
            $display("FAIL be0_no_write: got %h exp de22be44", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n; int bad;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        @(posedge clk);
        // Keep presenting a store while busy; it must be ignored.
        #1 req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44 || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin
            failed++;
            $display("FAIL hold_stable: got %0d bad cycles exp 0 (d=%h)", bad, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({dbg_state, req_ready, rsp_valid} !== {2'd0, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL release_idle: got s=%0d rdy=%b v=%b exp s=0 rdy=1 v=0",
                     dbg_state, req_ready, rsp_valid);
        end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if (rd !== 32'hDE22BE44) begin
            failed++;
            $display("FAIL ignored_req: got %h exp de22be44", rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int seen;
        issue(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (dbg_state !== 2'd1) begin
            failed++;
            $display("FAIL in_wait: got %0d exp 1", dbg_state);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            failed++;
            $display("FAIL abort_no_rsp: got %0d valid cycles exp 0", seen);
        end
        issue(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h0) begin
            failed++;
            $display("FAIL abort_no_write: got %h exp 00000000", rd);
        end
        // Reset while holding a response drops it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({rsp_valid, dbg_state, req_ready} !== {1'b0, 2'd0, 1'b1}) begin
            failed++;
            $display("FAIL reset_in_resp: got v=%b s=%0d rdy=%b exp v=0 s=0 rdy=1",
                     rsp_valid, dbg_state, req_ready);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
        tests++;
        if ({lat, er} !== {32'd3, 1'b1}) begin
            failed++;
            $display("FAIL oob_store: got lat=%0d e=%b exp lat=3 e=1", lat, er);
        end
        issue(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h0BADF00D) begin
            failed++;
            $display("FAIL oob_no_write: got %h exp 0badf00d", rd);
        end
        issue(1'b0, 32'h1002, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if ({lat, rd, er} !== {32'd3, 32'd0, 1'b1}) begin
            failed++;
            $display("FAIL oob_load: got lat=%0d d=%h e=%b exp lat=3 d=0 e=1", lat, rd, er);
        end
`else
        tests++;
        if ({lat, er} !== {32'd3, 1'b0}) begin
            failed++;
            $display("FAIL wrap_store: got lat=%0d e=%b exp lat=3 e=0", lat, er);
        end
        issue(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h12345678) begin
            failed++;
            $display("FAIL wrap_write: got %h exp 12345678", rd);
        end
        issue(1'b0, 32'h1002, 32'h0, 4'h0, rd, er, lat);
        tests++;
        if ({rd, er} !== {32'h12345678, 1'b0}) begin
            failed++;
            $display("FAIL wrap_load: got d=%h e=%b exp d=12345678 e=0", rd, er);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic        we_v [4];
        logic [31:0] wd_v [4];
        logic [3:0]  be_v [4];
        logic [31:0] exp_v [4];
        int last_acc;
        int n;
        we_v[0] = 1'b1; wd_v[0] = 32'hA5A50001; be_v[0] = 4'hF; exp_v[0] = 32'h0;
        we_v[1] = 1'b0; wd_v[1] = 32'h0;        be_v[1] = 4'h0; exp_v[1] = 32'hA5A50001;
        we_v[2] = 1'b1; wd_v[2] = 32'h0000BEEF; be_v[2] = 4'h3; exp_v[2] = 32'h0;
        we_v[3] = 1'b0; wd_v[3] = 32'h0;        be_v[3] = 4'h0; exp_v[3] = 32'hA5A5BEEF;
        last_acc = -1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!req_ready_0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            req_valid_0 = 1'b1; req_we_0 = we_v[k]; req_addr_0 = 32'h40;
            req_wdata_0 = wd_v[k]; req_be_0 = be_v[k];
            if (k > 0) begin
                tests++;
                if (cyc - last_acc !== 2) begin
                    failed++;
                    $display("FAIL b2b_interval[%0d]: got %0d exp 2", k, cyc - last_acc);
                end
            end
            last_acc = cyc;
            @(negedge clk);
            tests++;
            if ({rsp_valid_0, req_ready_0, rsp_rdata_0, rsp_err_0} !== {1'b1, 1'b0, exp_v[k], 1'b0}) begin
                failed++;
                $display("FAIL b2b_rsp[%0d]: got v=%b rdy=%b d=%h e=%b exp v=1 rdy=0 d=%h e=0",
                         k, rsp_valid_0, req_ready_0, rsp_rdata_0, rsp_err_0, exp_v[k]);
            end
            @(negedge clk);
        end
        req_valid_0 = 1'b0;
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0; req_be_0 = '0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_reset_abort();
        test_bounds();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
